// File: rtl/pcfetch_pkg.sv
// ---------------------------------------------------------------------------
// pcfetch_pkg
//
// Shared definitions for the PC / instruction-fetch stage:
//   - fetch_state_e : FSM state encoding (S_IDLE, S_REQ, S_OUT)
//   - DEFAULT_PC_W, DEFAULT_INSTR_W, DEFAULT_ACK_TIMEOUT : parameter defaults
//   - PCFETCH_RESET_PC : PC loaded when the stage is reset
//   - sat_inc32 : saturating 32-bit increment used by the optional
//                 performance counters (PCFETCH_PERF_CNT_EN)
// ---------------------------------------------------------------------------
package pcfetch_pkg;

    // State encoding is fixed so that waveforms read the same across builds.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_e;

    localparam int DEFAULT_PC_W        = 8;
    localparam int DEFAULT_INSTR_W     = 16;
    localparam int DEFAULT_ACK_TIMEOUT = 255;

    localparam logic [7:0] PCFETCH_RESET_PC = 8'h00;

    // Counters stick at all-ones instead of wrapping back to zero, so a
    // long-running count never looks smaller than it really is.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// ---------------------------------------------------------------------------
// fetch_timeout_counter
//
// Counts consecutive cycles that a fetch request has waited for its memory
// acknowledge and raises a one-cycle expire pulse on the cycle in which the
// count reaches ACK_TIMEOUT. The count restarts from zero after expiring.
//
// Parameters:
//   ACK_TIMEOUT : number of ack-less request cycles before expiry (1..65535)
//
// Ports:
//   clk    in  1  clock, posedge
//   reset  in  1  synchronous active-high reset
//   enable in  1  a request is waiting this cycle
//   clear  in  1  drop the count (ack arrived, request cancelled, not waiting)
//   expire out 1  combinational pulse: this cycle is the ACK_TIMEOUT-th wait
// ---------------------------------------------------------------------------
module fetch_timeout_counter
    import pcfetch_pkg::*;
#(
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    // The counter holds the number of waits already completed, so the wait
    // that brings it to ACK_TIMEOUT is the one where it currently reads
    // ACK_TIMEOUT-1. Sixteen bits cover the full legal timeout range.
    localparam logic [15:0] LAST_WAIT = 16'(ACK_TIMEOUT - 1);

    logic [15:0] count;

    // Expire is combinational so the FSM can react in the same cycle that
    // the final wait happens; clear always wins so a late ack never faults.
    assign expire = enable && !clear && (count == LAST_WAIT);

    // Count waits while enabled, wrapping to zero on expiry so a retried
    // request gets a fresh timeout window.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (expire) begin
                count <= '0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter and instruction-fetch stage. Keeps the PC, issues one
// outstanding request at a time to instruction memory, and hands each
// fetched word to decode through a valid/ready handshake. Restart requests
// (from the reset debouncer) and branches redirect fetch; an ack that does
// not arrive within ACK_TIMEOUT cycles raises o_fault and the same PC is
// retried.
//
// Optional feature (macro PCFETCH_PERF_CNT_EN): adds o_fetchCount and
// o_stallCount saturating performance counters. Without the macro neither
// the ports nor the counters exist.
//
// Parameters:
//   PC_W, INSTR_W, RESET_PC, ACK_TIMEOUT
//
// Ports:
//   i_clk           in   1        clock, posedge
//   i_reset         in   1        synchronous active-high reset
//   i_restart       in   1        restart request (overrides branch)
//   i_restartPc     in   PC_W     PC loaded on restart
//   i_branchValid   in   1        branch redirect strobe
//   i_branchTarget  in   PC_W     branch target
//   i_stall         in   1        blocks issue of a new fetch
//   o_memReq        out  1        fetch request, held until ack
//   o_memAddr       out  PC_W     fetch address
//   i_memAck        in   1        memory data valid this cycle
//   i_memData       in   INSTR_W  fetched word
//   o_instr         out  INSTR_W  instruction to decode
//   o_instrPc       out  PC_W     PC of o_instr
//   o_instrValid    out  1        o_instr valid
//   i_instrReady    in   1        decode accepts the instruction
//   o_fault         out  1        one-cycle pulse on ack timeout
//   o_fetchCount    out  32       decode handshakes (PCFETCH_PERF_CNT_EN)
//   o_stallCount    out  32       stalled idle/out cycles (PCFETCH_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import pcfetch_pkg::*;
#(
    parameter int              PC_W        = DEFAULT_PC_W,
    parameter int              INSTR_W     = DEFAULT_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC    = PC_W'(PCFETCH_RESET_PC),
    parameter int              ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_restart,
    input  logic [PC_W-1:0]    i_restartPc,
    input  logic               i_branchValid,
    input  logic [PC_W-1:0]    i_branchTarget,
    input  logic               i_stall,
    output logic               o_memReq,
    output logic [PC_W-1:0]    o_memAddr,
    input  logic               i_memAck,
    input  logic [INSTR_W-1:0] i_memData,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_instrPc,
    output logic               o_instrValid,
    input  logic               i_instrReady,
    output logic               o_fault
`ifdef PCFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        o_fetchCount,
    output logic [31:0]        o_stallCount
`endif
);

    fetch_state_e    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            handshake;
    logic            timer_enable;
    logic            timer_clear;
    logic            timer_expire;

    // Restart outranks a branch landing in the same cycle; both behave as a
    // redirect that abandons whatever is in flight.
    assign redirect    = i_restart || i_branchValid;
    assign redirect_pc = i_restart ? i_restartPc : i_branchTarget;

    // Only a word actually being presented can be consumed.
    assign handshake = (state == S_OUT) && o_instrValid && i_instrReady;

    // PC arithmetic is modulo 2^PC_W, so the top address wraps to zero.
    assign pc_next = pc + PC_W'(1);

    // The timeout window only runs while a request is waiting; any ack,
    // redirect or exit from S_REQ wipes it so a retry starts from zero.
    assign timer_enable = (state == S_REQ);
    assign timer_clear  = redirect || i_memAck || (state != S_REQ);

    fetch_timeout_counter #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timeout (
        .clk    (i_clk),
        .reset  (i_reset),
        .enable (timer_enable),
        .clear  (timer_clear),
        .expire (timer_expire)
    );

    // Fetch FSM with registered outputs. Every output is a register so
    // memory and decode see glitch-free, edge-aligned signals. A redirect
    // drops any request, discards any pending word and parks in S_IDLE so
    // the new target is fetched starting on the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            o_memReq     <= 1'b0;
            o_memAddr    <= RESET_PC;
            o_instr      <= '0;
            o_instrPc    <= '0;
            o_instrValid <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            o_fault <= 1'b0;
            if (redirect) begin
                state        <= S_IDLE;
                pc           <= redirect_pc;
                o_memReq     <= 1'b0;
                o_memAddr    <= redirect_pc;
                o_instrValid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Stall only gates the start of a new request.
                        if (!i_stall) begin
                            state     <= S_REQ;
                            o_memReq  <= 1'b1;
                            o_memAddr <= pc;
                        end
                    end
                    S_REQ: begin
                        if (i_memAck) begin
                            state        <= S_OUT;
                            o_memReq     <= 1'b0;
                            o_instr      <= i_memData;
                            o_instrPc    <= pc;
                            o_instrValid <= 1'b1;
                        end else if (timer_expire) begin
                            // Drop the request for one cycle and retry the
                            // same PC from S_IDLE.
                            state    <= S_IDLE;
                            o_memReq <= 1'b0;
                            o_fault  <= 1'b1;
                        end
                    end
                    S_OUT: begin
                        // Word and PC stay frozen until decode takes them.
                        if (handshake) begin
                            pc           <= pc_next;
                            o_instrValid <= 1'b0;
                            if (i_stall) begin
                                state <= S_IDLE;
                            end else begin
                                state     <= S_REQ;
                                o_memReq  <= 1'b1;
                                o_memAddr <= pc_next;
                            end
                        end
                    end
                    default: begin
                        state        <= S_IDLE;
                        o_memReq     <= 1'b0;
                        o_instrValid <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PCFETCH_PERF_CNT_EN
    // Performance counters. A restart clears them along with reset so a
    // debounced button press gives a fresh measurement window. A handshake
    // that coincides with a branch still counts as a consumed instruction.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_restart) begin
            o_fetchCount <= '0;
            o_stallCount <= '0;
        end else begin
            if (handshake) begin
                o_fetchCount <= sat_inc32(o_fetchCount);
            end
            if (i_stall && (state != S_REQ)) begin
                o_stallCount <= sat_inc32(o_stallCount);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Bench for pc_fetch_unit (ACK_TIMEOUT = 4). A reference model tracks what
// the fetch stage must show on its outputs, using the visible request/valid
// outputs themselves as its notion of progress, and is compared against the
// DUT on every falling edge. Directed scenarios add literal expectations.
// Optional counters are checked when PCFETCH_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam int TIMEOUT = 4;

    logic        i_clk;
    logic        i_reset;
    logic        i_restart;
    logic [7:0]  i_restartPc;
    logic        i_branchValid;
    logic [7:0]  i_branchTarget;
    logic        i_stall;
    logic        o_memReq;
    logic [7:0]  o_memAddr;
    logic        i_memAck;
    logic [15:0] i_memData;
    logic [15:0] o_instr;
    logic [7:0]  o_instrPc;
    logic        o_instrValid;
    logic        i_instrReady;
    logic        o_fault;
`ifdef PCFETCH_PERF_CNT_EN
    logic [31:0] o_fetchCount;
    logic [31:0] o_stallCount;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int mem_mode;
    int req_age;
    bit check_en = 1'b0;

    // Reference model state.
    logic [7:0]  m_pc;
    logic        m_req;
    logic [7:0]  m_addr;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [7:0]  m_instr_pc;
    logic        m_fault;
    int          m_wait;
    logic        m_redirect;
    logic [7:0]  m_target;
`ifdef PCFETCH_PERF_CNT_EN
    logic [31:0] m_fetch;
    logic [31:0] m_stall;
`endif

    pc_fetch_unit #(
        .PC_W        (8),
        .INSTR_W     (16),
        .RESET_PC    (8'h00),
        .ACK_TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_restart      (i_restart),
        .i_restartPc    (i_restartPc),
        .i_branchValid  (i_branchValid),
        .i_branchTarget (i_branchTarget),
        .i_stall        (i_stall),
        .o_memReq       (o_memReq),
        .o_memAddr      (o_memAddr),
        .i_memAck       (i_memAck),
        .i_memData      (i_memData),
        .o_instr        (o_instr),
        .o_instrPc      (o_instrPc),
        .o_instrValid   (o_instrValid),
        .i_instrReady   (i_instrReady),
        .o_fault        (o_fault)
`ifdef PCFETCH_PERF_CNT_EN
        ,
        .o_fetchCount   (o_fetchCount),
        .o_stallCount   (o_stallCount)
`endif
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Contents of instruction memory: high byte is the address XOR 0xA5.
    function automatic logic [15:0] mem_word(input logic [7:0] addr);
        return {addr ^ 8'hA5, addr};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one clock; just after the edge, act as instruction memory:
    // mode 1 acks on the second cycle of a request, mode 2 acks at once,
    // mode 0 never acks.
    task automatic applyStimulus();
        @(posedge i_clk);
        #1;
        if (o_memReq) req_age++;
        else req_age = 0;
        case (mem_mode)
            1:       i_memAck = o_memReq && (req_age >= 2);
            2:       i_memAck = o_memReq;
            default: i_memAck = 1'b0;
        endcase
        i_memData = mem_word(o_memAddr);
    endtask

    // Reference model: the stage is waiting on memory while a request is
    // out, holding a word while one is valid, and otherwise idle.
    always @(posedge i_clk) begin
        m_redirect = i_restart || i_branchValid;
        m_target   = i_restart ? i_restartPc : i_branchTarget;
        if (i_reset) begin
            m_pc       <= 8'h00;
            m_req      <= 1'b0;
            m_addr     <= 8'h00;
            m_valid    <= 1'b0;
            m_instr    <= 16'h0000;
            m_instr_pc <= 8'h00;
            m_fault    <= 1'b0;
            m_wait     <= 0;
        end else begin
            m_fault <= 1'b0;
            if (m_redirect) begin
                m_pc    <= m_target;
                m_req   <= 1'b0;
                m_valid <= 1'b0;
                m_wait  <= 0;
            end else if (m_valid) begin
                if (i_instrReady) begin
                    m_valid <= 1'b0;
                    m_pc    <= m_pc + 8'd1;
                    if (!i_stall) begin
                        m_req  <= 1'b1;
                        m_addr <= m_pc + 8'd1;
                    end
                end
            end else if (m_req) begin
                if (i_memAck) begin
                    m_req      <= 1'b0;
                    m_valid    <= 1'b1;
                    m_instr    <= mem_word(m_addr);
                    m_instr_pc <= m_addr;
                    m_wait     <= 0;
                end else if (m_wait + 1 == TIMEOUT) begin
                    m_fault <= 1'b1;
                    m_req   <= 1'b0;
                    m_wait  <= 0;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else if (!i_stall) begin
                m_req  <= 1'b1;
                m_addr <= m_pc;
            end
        end
`ifdef PCFETCH_PERF_CNT_EN
        if (i_reset || i_restart) begin
            m_fetch <= 32'd0;
            m_stall <= 32'd0;
        end else begin
            if (m_valid && i_instrReady && m_fetch != 32'hFFFF_FFFF) m_fetch <= m_fetch + 32'd1;
            if (i_stall && !m_req && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 32'd1;
        end
`endif
    end

    // Compare the DUT with the model on every falling edge.
    always @(negedge i_clk) begin
        if (check_en) begin
            checkOutput("memReq", 32'(o_memReq), 32'(m_req));
            if (m_req) checkOutput("memAddr", 32'(o_memAddr), 32'(m_addr));
            checkOutput("instrValid", 32'(o_instrValid), 32'(m_valid));
            if (m_valid) begin
                checkOutput("instr", 32'(o_instr), 32'(m_instr));
                checkOutput("instrPc", 32'(o_instrPc), 32'(m_instr_pc));
            end
            checkOutput("fault", 32'(o_fault), 32'(m_fault));
`ifdef PCFETCH_PERF_CNT_EN
            checkOutput("fetchCount", o_fetchCount, m_fetch);
            checkOutput("stallCount", o_stallCount, m_stall);
`endif
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        automatic logic [15:0] t1_words[4] = '{16'hA500, 16'hA401, 16'hA702, 16'hA603};
        int n;
        int req_cycles;

        i_reset = 1'b1; i_restart = 1'b0; i_restartPc = 8'h00;
        i_branchValid = 1'b0; i_branchTarget = 8'h00; i_stall = 1'b0;
        i_instrReady = 1'b1; i_memAck = 1'b0; i_memData = 16'h0000;
        mem_mode = 1; req_age = 0;

        applyStimulus();
        applyStimulus();
        check_en = 1'b1;
        checkOutput("rst_memReq", 32'(o_memReq), 32'd0);
        checkOutput("rst_instrValid", 32'(o_instrValid), 32'd0);
        checkOutput("rst_fault", 32'(o_fault), 32'd0);
        i_reset = 1'b0;

        // Streaming fetch: one instruction every three cycles.
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                applyStimulus();
                n++;
            end while (!o_instrValid && n < 10);
            checkOutput("t1_valid", 32'(o_instrValid), 32'd1);
            checkOutput("t1_pc", 32'(o_instrPc), 32'(k));
            checkOutput("t1_instr", 32'(o_instr), 32'(t1_words[k]));
            checkOutput("t1_gap", 32'(n), 32'd3);
        end

        // Decode back-pressure at pc 0x05.
        i_branchValid = 1'b1; i_branchTarget = 8'h05; i_instrReady = 1'b0;
        applyStimulus();
        i_branchValid = 1'b0;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!o_instrValid && n < 10);
        checkOutput("t2_valid", 32'(o_instrValid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            checkOutput("t2_hold_valid", 32'(o_instrValid), 32'd1);
            checkOutput("t2_hold_pc", 32'(o_instrPc), 32'h05);
            checkOutput("t2_hold_instr", 32'(o_instr), 32'hA005);
            checkOutput("t2_hold_noreq", 32'(o_memReq), 32'd0);
        end
        i_instrReady = 1'b1;
        applyStimulus();
        checkOutput("t2_after_valid", 32'(o_instrValid), 32'd0);
        checkOutput("t2_after_req", 32'(o_memReq), 32'd1);
        checkOutput("t2_after_addr", 32'(o_memAddr), 32'h06);

        // Branch coinciding with an ack: the word is dropped.
        i_branchValid = 1'b1; i_branchTarget = 8'h10;
        applyStimulus();
        i_branchValid = 1'b0;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!(i_memAck && o_memAddr == 8'h10) && n < 10);
        checkOutput("t3_req", 32'(o_memReq), 32'd1);
        checkOutput("t3_addr", 32'(o_memAddr), 32'h10);
        i_branchValid = 1'b1; i_branchTarget = 8'h40;
        applyStimulus();
        i_branchValid = 1'b0;
        checkOutput("t3_dropped", 32'(o_instrValid), 32'd0);
        checkOutput("t3_req_low", 32'(o_memReq), 32'd0);
        applyStimulus();
        checkOutput("t3_still_dropped", 32'(o_instrValid), 32'd0);
        checkOutput("t3_new_req", 32'(o_memReq), 32'd1);
        checkOutput("t3_new_addr", 32'(o_memAddr), 32'h40);

        // Restart beats a simultaneous branch; memory stops answering.
        mem_mode = 0;
        i_restart = 1'b1; i_restartPc = 8'h00;
        i_branchValid = 1'b1; i_branchTarget = 8'h20;
        applyStimulus();
        i_restart = 1'b0; i_branchValid = 1'b0;
        checkOutput("t4_req_low", 32'(o_memReq), 32'd0);
        applyStimulus();
        checkOutput("t4_req", 32'(o_memReq), 32'd1);
        checkOutput("t4_addr", 32'(o_memAddr), 32'h00);

        // Ack timeout after four waiting cycles, then a retry.
        req_cycles = 1;
        n = 0;
        do begin
            applyStimulus();
            n++;
            if (!o_fault && o_memReq) req_cycles++;
        end while (!o_fault && n < 20);
        checkOutput("t5_fault", 32'(o_fault), 32'd1);
        checkOutput("t5_req_dropped", 32'(o_memReq), 32'd0);
        checkOutput("t5_req_cycles", 32'(req_cycles), 32'd4);
        applyStimulus();
        checkOutput("t5_fault_pulse", 32'(o_fault), 32'd0);
        checkOutput("t5_retry_req", 32'(o_memReq), 32'd1);
        checkOutput("t5_retry_addr", 32'(o_memAddr), 32'h00);

        // Wrap from 0xFF, then stall after the handshake.
        mem_mode = 1;
        i_branchValid = 1'b1; i_branchTarget = 8'hFF;
        applyStimulus();
        i_branchValid = 1'b0;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!o_instrValid && n < 10);
        checkOutput("t6_valid", 32'(o_instrValid), 32'd1);
        checkOutput("t6_pc", 32'(o_instrPc), 32'hFF);
        checkOutput("t6_instr", 32'(o_instr), 32'h5AFF);
        i_stall = 1'b1;
        applyStimulus();
        checkOutput("t6_consumed", 32'(o_instrValid), 32'd0);
        checkOutput("t6_model_wrap_pc", 32'(m_pc), 32'h00);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t6_stall_noreq", 32'(o_memReq), 32'd0);
            applyStimulus();
        end
        i_stall = 1'b0;
        applyStimulus();
        checkOutput("t6_req", 32'(o_memReq), 32'd1);
        checkOutput("t6_wrap_addr", 32'(o_memAddr), 32'h00);

        // Reset in the middle of a fetch returns everything to rest values.
        i_branchValid = 1'b1; i_branchTarget = 8'h33;
        applyStimulus();
        i_branchValid = 1'b0;
        applyStimulus();
        i_reset = 1'b1;
        applyStimulus();
        checkOutput("t7_memReq", 32'(o_memReq), 32'd0);
        checkOutput("t7_memAddr", 32'(o_memAddr), 32'h00);
        checkOutput("t7_instrValid", 32'(o_instrValid), 32'd0);
        checkOutput("t7_instr", 32'(o_instr), 32'h0000);
        checkOutput("t7_instrPc", 32'(o_instrPc), 32'h00);
        checkOutput("t7_fault", 32'(o_fault), 32'd0);
        i_reset = 1'b0;
        for (int k = 0; k < 6; k++) applyStimulus();

        @(posedge i_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
